// File: rtl/ristretto_prefetch_unit_if.sv
// Instruction-memory request/response bus shared by the prefetch unit (master) and memory (slave).
interface ristretto_prefetch_unit_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                 pf_instr_req_o;
    logic [AddrWidth-1:0] pf_instr_addr_o;
    logic                 pf_instr_ready_i;
    logic                 pf_instr_valid_i;
    logic [DataWidth-1:0] pf_instr_rdata_i;

    modport master (
        output pf_instr_req_o, pf_instr_addr_o,
        input  pf_instr_ready_i, pf_instr_valid_i, pf_instr_rdata_i
    );

    modport slave (
        input  pf_instr_req_o, pf_instr_addr_o,
        output pf_instr_ready_i, pf_instr_valid_i, pf_instr_rdata_i
    );
endinterface

// File: rtl/ristretto_prefetch_unit.sv
// Pipelined instruction prefetcher: several requests in flight, {data, pc} FIFO toward IF,
// flush/redirect that drops stale responses, and NOP injection on hazards.
module ristretto_prefetch_unit #(
    parameter int                   DataWidth      = 32,
    parameter int                   AddrWidth      = 32,
    parameter int                   FifoDepth      = 4,
    parameter int                   MaxOutstanding = 2,
    parameter logic [AddrWidth-1:0] BootAddr       = AddrWidth'(32'h0000_0080)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    ristretto_prefetch_unit_if.master    mem,
    input  logic                         pf_fetch_en_i,
    input  logic                         pf_flush_i,
    input  logic [AddrWidth-1:0]         pf_flush_addr_i,
    output logic [DataWidth-1:0]         pf_instr_o,
    output logic [AddrWidth-1:0]         pf_instr_pc_o,
    output logic                         pf_instr_valid_o,
    input  logic                         pf_id_ready_i,
    output logic [1:0]                   pf_penality_o,
    input  logic                         pf_trap_hazard_flag_i,
    input  logic                         pf_ctrl_hazard_flag_i,
    output logic                         pf_busy_o,
    output logic [$clog2(FifoDepth):0]   pf_occupancy_o
);
    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = PtrW + 1;
    localparam int OsW  = $clog2(MaxOutstanding + 1);
    localparam int PqW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int SumW = CntW + 1;
    localparam logic [DataWidth-1:0] Nop = DataWidth'(32'h0000_0013);

    logic [AddrWidth-1:0] fetch_addr_q;
    logic                 req_q, req_n;
    logic [OsW-1:0]       outstanding_q, outstanding_n;
    logic [OsW-1:0]       discard_q, discard_n;
    logic [CntW-1:0]      count_q, count_n;
    logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [PqW-1:0]       pcq_rd_q, pcq_wr_q;
    logic [SumW-1:0]      live_sum;

    logic [DataWidth-1:0] fifo_data [FifoDepth];
    logic [AddrWidth-1:0] fifo_pc   [FifoDepth];
    logic [AddrWidth-1:0] pcq       [MaxOutstanding];

    logic accept, resp, drop, push, pop;

    function automatic logic [PqW-1:0] pcq_next(input logic [PqW-1:0] p);
        return (p == PqW'(MaxOutstanding - 1)) ? '0 : p + PqW'(1);
    endfunction

    assign accept = req_q & mem.pf_instr_ready_i;
    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign resp   = mem.pf_instr_valid_i & (outstanding_q != '0);
    assign drop   = resp & (discard_q != '0);
    assign push   = resp & ~drop & ~pf_flush_i;
    assign pop    = pf_instr_valid_o & pf_id_ready_i & ~pf_flush_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        outstanding_n = outstanding_q + OsW'(accept) - OsW'(resp);
        discard_n     = discard_q;
        count_n       = count_q;
        req_n         = 1'b0;

        if (pf_flush_i) begin
            discard_n = outstanding_n;
            count_n   = '0;
        end else begin
            if (drop) discard_n = discard_q - OsW'(1);
            count_n = count_q + CntW'(push) - CntW'(pop);
        end

        // Live responses must always find a FIFO slot, so a new request is only raised if one is free.
        live_sum = SumW'(count_n) + SumW'(outstanding_n - discard_n);

        if (pf_flush_i) begin
            req_n = 1'b0;
        end else if (req_q && !mem.pf_instr_ready_i) begin
            req_n = 1'b1;
        end else begin
            req_n = pf_fetch_en_i && (outstanding_n < OsW'(MaxOutstanding))
                    && (live_sum < SumW'(FifoDepth));
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_addr_q  <= BootAddr;
            req_q         <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            pcq_rd_q      <= '0;
            pcq_wr_q      <= '0;
        end else begin
            req_q         <= req_n;
            outstanding_q <= outstanding_n;
            discard_q     <= discard_n;
            count_q       <= count_n;

            if (pf_flush_i)  fetch_addr_q <= pf_flush_addr_i;
            else if (accept) fetch_addr_q <= fetch_addr_q + AddrWidth'(4);

            if (accept) pcq_wr_q <= pcq_next(pcq_wr_q);
            if (resp)   pcq_rd_q <= pcq_next(pcq_rd_q);

            if (pf_flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // NOTE: storage arrays are not reset; pointers and counts alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (accept) pcq[pcq_wr_q] <= fetch_addr_q;
        if (push) begin
            fifo_data[wr_ptr_q] <= mem.pf_instr_rdata_i;
            fifo_pc[wr_ptr_q]   <= pcq[pcq_rd_q];
        end
    end

    assign mem.pf_instr_req_o  = req_q;
    assign mem.pf_instr_addr_o = fetch_addr_q;

    assign pf_instr_valid_o = (count_q != '0);
    assign pf_instr_o       = (pf_trap_hazard_flag_i || pf_ctrl_hazard_flag_i || !pf_instr_valid_o)
                              ? Nop : fifo_data[rd_ptr_q];
    // With an empty FIFO the PC shows the next fetch address, which is BootAddr out of reset.
    assign pf_instr_pc_o    = pf_instr_valid_o ? fifo_pc[rd_ptr_q] : fetch_addr_q;
    assign pf_penality_o    = {pf_trap_hazard_flag_i, pf_ctrl_hazard_flag_i};
    assign pf_busy_o        = (outstanding_q != '0) || req_q;
    assign pf_occupancy_o   = count_q;
endmodule

// File: tb/tb_ristretto_prefetch_unit.sv
// Directed bench for ristretto_prefetch_unit: fixed-latency memory model returning address as data.
module tb_ristretto_prefetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = '0;
    logic        id_ready = 1'b0;
    logic        trap_flag = 1'b0;
    logic        ctrl_flag = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid_o;
    logic [1:0]  penality;
    logic        busy;
    logic [2:0]  occ;

    int total = 0;
    int bad = 0;
    int mem_lat = 1;

    ristretto_prefetch_unit_if #(.DataWidth(32), .AddrWidth(32)) bus ();

    ristretto_prefetch_unit dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .mem                   (bus),
        .pf_fetch_en_i         (fetch_en),
        .pf_flush_i            (flush),
        .pf_flush_addr_i       (flush_addr),
        .pf_instr_o            (instr),
        .pf_instr_pc_o         (pc),
        .pf_instr_valid_o      (valid_o),
        .pf_id_ready_i         (id_ready),
        .pf_penality_o         (penality),
        .pf_trap_hazard_flag_i (trap_flag),
        .pf_ctrl_hazard_flag_i (ctrl_flag),
        .pf_busy_o             (busy),
        .pf_occupancy_o        (occ)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are changed and outputs sampled 1 time unit after the falling edge.
    task automatic cycle();
        @(negedge clk_i);
        #1;
    endtask

    // Memory: accepts whenever ready is high, answers in order after mem_lat cycles.
    initial begin
        logic [31:0] q_addr[$];
        int          q_due[$];
        int          mcyc;
        mcyc = 0;
        bus.pf_instr_valid_i = 1'b0;
        bus.pf_instr_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            #2;
            mcyc++;
            bus.pf_instr_valid_i = 1'b0;
            if (rst_i) begin
                q_addr.delete();
                q_due.delete();
            end else begin
                if (q_due.size() > 0 && q_due[0] == mcyc) begin
                    bus.pf_instr_valid_i = 1'b1;
                    bus.pf_instr_rdata_i = q_addr.pop_front();
                    void'(q_due.pop_front());
                end
                if (bus.pf_instr_req_o && bus.pf_instr_ready_i) begin
                    q_addr.push_back(bus.pf_instr_addr_o);
                    q_due.push_back(mcyc + mem_lat);
                end
            end
        end
    end

    task automatic do_reset(input int lat);
        rst_i = 1'b1;
        fetch_en = 1'b0;
        flush = 1'b0;
        id_ready = 1'b0;
        trap_flag = 1'b0;
        ctrl_flag = 1'b0;
        bus.pf_instr_ready_i = 1'b1;
        mem_lat = lat;
        repeat (3) cycle();
        check("rst_req",   32'(bus.pf_instr_req_o), 32'd0);
        check("rst_addr",  bus.pf_instr_addr_o, 32'h80);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr, 32'h13);
        check("rst_pc",    pc, 32'h80);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_occ",   32'(occ), 32'd0);
        rst_i = 1'b0;
    endtask

    // Observes n pops in address order starting at first; running out of budget counts as a failure.
    task automatic drain(input int n, input logic [31:0] first, input int budget);
        logic [31:0] exp_pc;
        int got;
        int used;
        exp_pc = first;
        got = 0;
        used = 0;
        while (got < n && used < budget) begin
            cycle();
            used++;
            if (valid_o && id_ready) begin
                check("stream_pc", pc, exp_pc);
                check("stream_instr", instr, exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        if (got < n) check("stream_words_within_budget", 32'(got), 32'(n));
    endtask

    initial begin
        bus.pf_instr_ready_i = 1'b1;

        // Reset then steady fetch with a 1-cycle memory
        do_reset(1);
        cycle(); fetch_en = 1'b1; id_ready = 1'b1;
        cycle();
        check("t1_req_c1", 32'(bus.pf_instr_req_o), 32'd1);
        check("t1_addr_c1", bus.pf_instr_addr_o, 32'h80);
        check("t1_valid_c1", 32'(valid_o), 32'd0);
        cycle();
        check("t1_valid_c2", 32'(valid_o), 32'd0);
        cycle();
        check("t1_valid_c3", 32'(valid_o), 32'd1);
        check("t1_instr_c3", instr, 32'h80);
        check("t1_pc_c3", pc, 32'h80);
        drain(5, 32'h84, 5);

        // Back-pressure: FIFO fills to 4, requests stop, then everything streams out in order
        do_reset(1);
        cycle(); fetch_en = 1'b1; id_ready = 1'b0;
        for (int i = 1; i < 10; i++) begin
            cycle();
            check("t2_occ_le_4", 32'(occ <= 3'd4), 32'd1);
        end
        cycle();
        check("t2_occ_full", 32'(occ), 32'd4);
        check("t2_req_off", 32'(bus.pf_instr_req_o), 32'd0);
        check("t2_busy_off", 32'(busy), 32'd0);
        check("t2_head_instr", instr, 32'h80);
        check("t2_head_pc", pc, 32'h80);
        id_ready = 1'b1;
        drain(8, 32'h84, 12);

        // Flush with 2 in flight, 3-cycle memory
        do_reset(3);
        cycle(); fetch_en = 1'b1; id_ready = 1'b0;
        cycle();
        cycle();
        cycle();
        check("t3_req_c3", 32'(bus.pf_instr_req_o), 32'd0);
        check("t3_busy_c3", 32'(busy), 32'd1);
        flush = 1'b1; flush_addr = 32'h200;
        cycle(); flush = 1'b0;
        check("t3_req_after_flush", 32'(bus.pf_instr_req_o), 32'd0);
        check("t3_valid_c4", 32'(valid_o), 32'd0);
        cycle();
        check("t3_req_redirect", 32'(bus.pf_instr_req_o), 32'd1);
        check("t3_addr_redirect", bus.pf_instr_addr_o, 32'h200);
        for (int i = 6; i < 9; i++) begin
            cycle();
            check("t3_no_stale", 32'(valid_o), 32'd0);
        end
        cycle();
        check("t3_valid_c9", 32'(valid_o), 32'd1);
        check("t3_pc_c9", pc, 32'h200);
        check("t3_instr_c9", instr, 32'h200);
        id_ready = 1'b1;
        drain(2, 32'h204, 8);

        // Flush in the same cycle as an accept and a response
        do_reset(1);
        cycle(); fetch_en = 1'b1; id_ready = 1'b1;
        cycle();
        cycle();
        check("t4_req_c2", 32'(bus.pf_instr_req_o), 32'd1);
        check("t4_addr_c2", bus.pf_instr_addr_o, 32'h84);
        flush = 1'b1; flush_addr = 32'h300;
        cycle(); flush = 1'b0;
        check("t4_valid_c3", 32'(valid_o), 32'd0);
        check("t4_occ_c3", 32'(occ), 32'd0);
        check("t4_req_c3", 32'(bus.pf_instr_req_o), 32'd0);
        check("t4_busy_c3", 32'(busy), 32'd1);
        cycle();
        check("t4_req_c4", 32'(bus.pf_instr_req_o), 32'd1);
        check("t4_addr_c4", bus.pf_instr_addr_o, 32'h300);
        check("t4_valid_c4", 32'(valid_o), 32'd0);
        cycle();
        check("t4_valid_c5", 32'(valid_o), 32'd0);
        cycle();
        check("t4_valid_c6", 32'(valid_o), 32'd1);
        check("t4_pc_c6", pc, 32'h300);
        check("t4_instr_c6", instr, 32'h300);
        drain(3, 32'h304, 3);

        // Hold rule: memory stalls for 5 cycles while fetch_en drops
        do_reset(1);
        cycle(); fetch_en = 1'b1; id_ready = 1'b0; bus.pf_instr_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cycle(); fetch_en = 1'b0;
            check("t5_req_held", 32'(bus.pf_instr_req_o), 32'd1);
            check("t5_addr_held", bus.pf_instr_addr_o, 32'h80);
        end
        cycle(); bus.pf_instr_ready_i = 1'b1;
        check("t5_req_c6", 32'(bus.pf_instr_req_o), 32'd1);
        cycle();
        check("t5_req_c7", 32'(bus.pf_instr_req_o), 32'd0);
        check("t5_busy_c7", 32'(busy), 32'd1);
        cycle();
        check("t5_valid_c8", 32'(valid_o), 32'd1);
        check("t5_pc_c8", pc, 32'h80);
        check("t5_occ_c8", 32'(occ), 32'd1);
        check("t5_busy_c8", 32'(busy), 32'd0);

        // Hazard flags with one entry held in the FIFO
        cycle(); ctrl_flag = 1'b1; #1;
        check("t6_ctrl_instr", instr, 32'h13);
        check("t6_ctrl_pen", 32'(penality), 32'd1);
        check("t6_ctrl_occ", 32'(occ), 32'd1);
        cycle(); ctrl_flag = 1'b0; trap_flag = 1'b1; #1;
        check("t6_trap_instr", instr, 32'h13);
        check("t6_trap_pen", 32'(penality), 32'd2);
        check("t6_trap_occ", 32'(occ), 32'd1);
        cycle(); trap_flag = 1'b0; #1;
        check("t6_clear_instr", instr, 32'h80);
        check("t6_clear_pen", 32'(penality), 32'd0);
        check("t6_clear_valid", 32'(valid_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t reached limit, expected bench to finish earlier", $time);
        $fatal(1);
    end
endmodule

// File: doc/ristretto_prefetch_unit.md
# ristretto_prefetch_unit

Parametrised successor to the single-shot instruction fetch unit. It keeps up to `MaxOutstanding` instruction-memory requests in flight and buffers the returned words, with their PCs, in a `FifoDepth`-entry prefetch FIFO. Within one response it supports flush/redirect on branch or trap, discarding stale in-flight responses. It sits between the instruction-memory protocol and the IF stage, and keeps the NOP-injection/penality contract toward the pipeline.

## Interface
- `DataWidth`, 32: instruction word width.
- `AddrWidth`, 32: fetch address width.
- `FifoDepth`, 4: prefetch FIFO entries; power of two, ≥2.
- `MaxOutstanding`, 2: max accepted-but-unanswered requests; 1..FifoDepth.
- `BootAddr`, 32'h0000_0080: fetch address after reset.
- `clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `pf_fetch_en_i` in 1: permits issuing new requests.
- `pf_flush_i` in 1: redirect; empties the FIFO and restarts fetch at `pf_flush_addr_i`.
- `pf_flush_addr_i` in AddrWidth: redirect target, word aligned.
- `pf_instr_req_o` out 1: memory request.
- `pf_instr_addr_o` out AddrWidth: request address.
- `pf_instr_ready_i` in 1: request accepted this cycle when high with `req_o`.
- `pf_instr_valid_i` in 1: one response word this cycle; responses are in order.
- `pf_instr_rdata_i` in DataWidth: response data.
- `pf_instr_o` out DataWidth: head instruction, or NOP 32'h00000013.
- `pf_instr_pc_o` out AddrWidth: PC of the head entry.
- `pf_instr_valid_o` out 1: FIFO non-empty.
- `pf_id_ready_i` in 1: consumer pops the head when high with `valid_o`.
- `pf_penality_o` out 2: bit0 = ctrl hazard, bit1 = trap hazard.
- `pf_trap_hazard_flag_i`, `pf_ctrl_hazard_flag_i` in 1: hazard flags; force a NOP on `pf_instr_o`.
- `pf_busy_o` out 1: outstanding count ≠ 0 or `req_o` high.
- `pf_occupancy_o` out $clog2(FifoDepth)+1: FIFO count.

## Operation
- **Registers:**
  - `fetch_addr`: next request address.
  - `outstanding`: accepted requests not yet answered.
  - `discard`: responses still to be dropped.
  - FIFO of {data, pc}, with count.
- **Issue:**
  - Next-cycle `req_o` = `fetch_en_i` & !`flush_i` & (`outstanding` < MaxOutstanding) & (count + (`outstanding` − `discard`) + pending < FifoDepth).
  - `pending` is a raised but unaccepted request.
  - The invariant guarantees every live response has a FIFO slot; no response is ever dropped for lack of space.
- **Hold rule:** once raised, `req_o` and `addr_o` stay stable until `ready_i`, even if `fetch_en_i` falls. The only exception is flush (below).
- **Accept** (`req_o` & `ready_i`):
  - `fetch_addr` += 4, wrapping modulo 2^AddrWidth.
  - `outstanding`++.
  - The PC is recorded in an in-order PC queue of MaxOutstanding entries.
- **Response** (`valid_i`):
  - `outstanding`−−.
  - If `discard` > 0: `discard`−−, word dropped.
  - Otherwise push {rdata, pc}.
  - `valid_i` with `outstanding` = 0 is a protocol error: ignored, no counter change.
- **Pop:** `valid_o` & `id_ready_i`. Simultaneous push and pop leaves the count unchanged.
- **Flush:**
  - FIFO is emptied (count 0).
  - `fetch_addr` ← `flush_addr_i`.
  - `req_o` is dropped the next cycle, even if unaccepted.
  - `discard` ← `outstanding` + accept_this_cycle − valid_this_cycle. Every in-flight response, including one accepted in the flush cycle, is discarded.
  - A response arriving in the flush cycle is dropped.
  - Pop and push in the flush cycle are void.
  - New requests may issue while `discard` > 0; ordering guarantees the stale words arrive first.
- **Output:**
  - `pf_instr_o` = NOP if either hazard flag is set or the FIFO is empty; otherwise head data.
  - `pf_penality_o` = {trap, ctrl}, combinational from the flags.
  - Hazard flags do not pop or flush.

## Timing
- **Reset values:** `req_o` 0, `addr_o`/`fetch_addr` BootAddr, `outstanding` 0, `discard` 0, count 0, `valid_o` 0, `instr_o` NOP, `pc_o` BootAddr, `busy_o` 0, `occupancy_o` 0.
- **Reset mid-operation:** all in-flight requests are forgotten; memory must be reset with the unit.
- `req_o` is registered: `fetch_en_i` high in cycle 0 gives `req_o` in cycle 1.
- **Latency with a 1-cycle memory:**
  - accept in cycle 1;
  - `valid_i` in cycle 2;
  - `valid_o` in cycle 3, since the FIFO output is registered.
- **Throughput:** with MaxOutstanding ≥ 2 and the consumer always ready, one instruction per cycle.
- **Flush:** in cycle t, `req_o` = 0 in t+1 and the first redirected request goes out in t+2 at the earliest. Redirected instruction at `valid_o` ≥ t+4 with a 1-cycle memory.
- **Hazard/penality outputs:** pure combinational, same cycle.

## Test plan
- **Reset then steady fetch:**
  - Stimulus: 1-cycle memory returning addr as data; `fetch_en` = 1, `id_ready` = 1.
  - Required: first `valid_o` 3 cycles after `fetch_en`, `instr_o` = 0x80, `pc_o` = 0x80, then 0x84, 0x88… with one per cycle.
- **Back-pressure:**
  - Stimulus: `id_ready` = 0.
  - Required: `occupancy_o` reaches 4 and never exceeds it, `req_o` falls, no word is lost; releasing `id_ready` streams all entries in order.
- **Flush with 2 in flight:**
  - Stimulus: memory latency 3; flush to 0x200.
  - Required: the 2 stale responses are dropped; the next `valid_o` has `pc_o` = 0x200.
- **Flush colliding with a response and an accept in the same cycle:**
  - Required: `discard` = `outstanding` + 1 − 1; no stale word appears at the output.
- **Hold rule:**
  - Stimulus: `ready_i` low for 5 cycles while `fetch_en` drops.
  - Required: `req_o`/`addr_o` stay stable until accepted.
- **Hazard flags:**
  - Stimulus: ctrl flag with a non-empty FIFO.
  - Required: `instr_o` = 0x13, penality = 2'b01, occupancy unchanged.
  - Stimulus: trap flag.
  - Required: penality = 2'b10.
